// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter sharing one AND/ADD ALU
// A single result register (EMPTY/FULL) holds one result; it accepts a new op whenever it is empty or draining.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_f,
  input  logic             req0_no,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_f,
  input  logic             req1_no,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_data;

  logic             w_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_f;
  logic             w_no;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_alu;

  assign w_free = (r_state == S_EMPTY) || res_ready;

  // On a tie, requester 1 wins only if requester 0 was granted last.
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
  assign w_gnt0 = req0_valid && !w_gnt1;

  assign req0_ready = rst_n && w_free && w_gnt0;
  assign req1_ready = rst_n && w_free && w_gnt1;
  assign w_xfer     = req0_ready || req1_ready;

  assign w_a   = w_gnt1 ? req1_a  : req0_a;
  assign w_b   = w_gnt1 ? req1_b  : req0_b;
  assign w_f   = w_gnt1 ? req1_f  : req0_f;
  assign w_no  = w_gnt1 ? req1_no : req0_no;
  assign w_t   = w_f ? (w_a + w_b) : (w_a & w_b);
  assign w_alu = w_no ? ~w_t : w_t;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
      S_FULL:  if (res_ready && !w_xfer) w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_res_data   <= w_alu;
        r_res_id     <= w_gnt1;
        r_last_grant <= w_gnt1;
      end
    end
  end

  assign res_valid = (r_state == S_FULL);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule
